// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-16 control sequencer: opcodes, T-state
// encoding and the control word that the datapath consumes.
package sap_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_LDI = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;
  localparam logic [7:0] OP_JC  = 8'h07;
  localparam logic [7:0] OP_JZ  = 8'h08;
  localparam logic [7:0] OP_OUT = 8'h0E;
  localparam logic [7:0] OP_HLT = 8'h0F;

  // T-state encoding; the raw value is also the debug t_state output.
  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd7
  } state_t;

  // One bit per datapath strobe.
  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic pc_write;
    logic mar_write;
    logic mem_oe;
    logic mem_write;
    logic ir_write;
    logic ir_oe;
    logic a_write;
    logic a_oe;
    logic b_write;
    logic alu_oe;
    logic alu_sub;
    logic flags_write;
    logic out_write;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational step decoder: maps (state, opcode, flags, mem_ready) to the
// control word for this cycle and the state for the next one.
// Memory steps hold their bus driver and state until mem_ready, and gate the
// write/increment strobe with mem_ready.
module ctrl_decode
  import sap_pkg::*;
(
  input  state_t     i_state,
  input  logic [7:0] i_opcode,
  input  logic       i_flag_c,
  input  logic       i_flag_z,
  input  logic       i_mem_ready,
  output ctrl_word_t o_cw,
  output state_t     o_next
);

  // Decode the current step; anything unlisted falls back to idle / T0.
  always_comb begin
    o_cw   = '0;
    o_next = ST_T0;
    case (i_state)
      ST_T0: begin
        o_cw.pc_oe     = 1'b1;
        o_cw.mar_write = 1'b1;
        o_next         = ST_T1;
      end
      ST_T1: begin
        o_cw.mem_oe   = 1'b1;
        o_cw.ir_write = i_mem_ready;
        o_cw.pc_inc   = i_mem_ready;
        o_next        = i_mem_ready ? ST_T2 : ST_T1;
      end
      ST_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_cw.ir_oe     = 1'b1;
            o_cw.mar_write = 1'b1;
            o_next         = ST_T3;
          end
          OP_LDI: begin
            o_cw.ir_oe   = 1'b1;
            o_cw.a_write = 1'b1;
          end
          OP_JMP: begin
            o_cw.ir_oe    = 1'b1;
            o_cw.pc_write = 1'b1;
          end
          OP_JC: begin
            o_cw.ir_oe    = i_flag_c;
            o_cw.pc_write = i_flag_c;
          end
          OP_JZ: begin
            o_cw.ir_oe    = i_flag_z;
            o_cw.pc_write = i_flag_z;
          end
          OP_OUT: begin
            o_cw.a_oe      = 1'b1;
            o_cw.out_write = 1'b1;
          end
          OP_HLT:  o_next = ST_HALT;
          default: o_next = ST_T0;
        endcase
      end
      ST_T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_cw.mem_oe  = 1'b1;
            o_cw.a_write = i_mem_ready;
            o_next       = i_mem_ready ? ST_T0 : ST_T3;
          end
          OP_ADD, OP_SUB: begin
            o_cw.mem_oe  = 1'b1;
            o_cw.b_write = i_mem_ready;
            o_next       = i_mem_ready ? ST_T4 : ST_T3;
          end
          OP_STA: begin
            o_cw.a_oe      = 1'b1;
            o_cw.mem_write = i_mem_ready;
            o_next         = i_mem_ready ? ST_T0 : ST_T3;
          end
          default: o_next = ST_T0;
        endcase
      end
      ST_T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_cw.alu_oe      = 1'b1;
          o_cw.a_write     = 1'b1;
          o_cw.flags_write = 1'b1;
          o_cw.alu_sub     = (i_opcode == OP_SUB);
        end
        o_next = ST_T0;
      end
      ST_HALT: o_next = ST_HALT;
      default: o_next = ST_T0;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// SAP-16 control sequencer: owns the T-state register and forces every strobe
// low while rst is high, so nothing partial escapes an abandoned instruction.
module ctrl_seq
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       mem_ready,
  output logic       pc_oe,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       mar_write,
  output logic       mem_oe,
  output logic       mem_write,
  output logic       ir_write,
  output logic       ir_oe,
  output logic       a_write,
  output logic       a_oe,
  output logic       b_write,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_write,
  output logic       out_write,
  output logic [2:0] t_state,
  output logic       halted
);

  state_t     r_state;
  state_t     w_next;
  ctrl_word_t w_cw;
  ctrl_word_t w_cw_gated;

  ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_flag_c    (flag_c),
    .i_flag_z    (flag_z),
    .i_mem_ready (mem_ready),
    .o_cw        (w_cw),
    .o_next      (w_next)
  );

  // State register: reset always lands in T0, even from HALT or a memory wait.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_T0;
    else     r_state <= w_next;
  end

  assign w_cw_gated  = rst ? '0 : w_cw;

  assign pc_oe       = w_cw_gated.pc_oe;
  assign pc_inc      = w_cw_gated.pc_inc;
  assign pc_write    = w_cw_gated.pc_write;
  assign mar_write   = w_cw_gated.mar_write;
  assign mem_oe      = w_cw_gated.mem_oe;
  assign mem_write   = w_cw_gated.mem_write;
  assign ir_write    = w_cw_gated.ir_write;
  assign ir_oe       = w_cw_gated.ir_oe;
  assign a_write     = w_cw_gated.a_write;
  assign a_oe        = w_cw_gated.a_oe;
  assign b_write     = w_cw_gated.b_write;
  assign alu_oe      = w_cw_gated.alu_oe;
  assign alu_sub     = w_cw_gated.alu_sub;
  assign flags_write = w_cw_gated.flags_write;
  assign out_write   = w_cw_gated.out_write;

  assign t_state     = r_state;
  assign halted      = (r_state == ST_HALT) && !rst;

  // Bus and strobe invariants the datapath relies on.
  a_single_driver: assert property (@(posedge clk) disable iff (rst)
    $onehot0({pc_oe, mem_oe, ir_oe, a_oe, alu_oe}));
  a_pc_excl: assert property (@(posedge clk) disable iff (rst)
    !(pc_inc && pc_write));
  a_mem_excl: assert property (@(posedge clk) disable iff (rst)
    !(mem_oe && mem_write));

endmodule
